chunked_addsub_seq: RTL and testbench
=====================================

// Module: chunked_addsub_seq
// PURPOSE
//  Parametrised multi-cycle ripple adder/subtractor; next generation of the 32-bit RCA.
//  Processes WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register.
//  Adds a subtract mode, a signed-overflow flag and valid/ready handshakes on input and output.
//  Sits between operand producers and result consumers that tolerate NCHUNK-cycle latency.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; >= 1
//  CHUNK  8   bits added per cycle; WIDTH % CHUNK == 0 (elaboration $error otherwise)
//  (derived) NCHUNK = WIDTH/CHUNK, the number of RUN cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands and mode valid
//  in_ready   out  1      block can accept; = (state==IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+cin   1: a-b-cin
//  out_valid  out  1      result valid; = (state==DONE)
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  result, mod 2^WIDTH
//  cout       out  1      add: carry-out; sub: borrow-out (1 = a < b+cin, unsigned)
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (rst_n low, async): state=IDLE, chunk index=0, carry=0, sum=0, cout=0, ovf=0,
//    out_valid=0, in_ready=1. Abandons any operation in progress; no result is produced.
//  - FSM: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after chunk NCHUNK-1;
//    DONE -> IDLE on out_ready. No other transitions.
//  - Accept edge: latch a; latch b_eff = sub ? ~b : b; carry = sub ? ~cin : cin; latch sub;
//    chunk index=0.
//  - RUN: on each edge, chunk i = bits [i*CHUNK +: CHUNK] gets {c,s} = a_i + b_eff_i + carry;
//    s is written into sum[i*CHUNK +: CHUNK]; carry <= c; i increments.
//  - Final chunk edge: cout = sub ? ~c : c; ovf = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]).
//  - Latency: out_valid rises exactly NCHUNK cycles after the accept edge.
//    CHUNK==WIDTH gives 1 cycle.
//  - sum/cout/ovf are meaningful only while out_valid=1. They hold stable while
//    out_valid && !out_ready, for any stall length.
//  - in_ready=0 during RUN and DONE; in_valid is ignored there. Producers hold their data.
//  - No same-cycle turnaround: the DONE handshake edge returns to IDLE. The next accept
//    occurs no earlier than the following edge.
//  - in_valid, a, b, cin and sub are sampled only on the accept edge. Later changes do not
//    affect the running operation.
//  - Carry wraps out of bit WIDTH-1 into cout only; sum is always mod 2^WIDTH.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//  1. a=0,b=0,cin=0,sub=0 -> sum=0,cout=0,ovf=0; out_valid exactly 4 cycles after accept
//  2. a=FFFFFFFF,b=1,cin=0 -> sum=0,cout=1,ovf=0. a=7FFFFFFF,b=1 -> sum=80000000,cout=0,ovf=1
//  3. a=12345678,b=87654321,cin=1 -> sum=9999999A,cout=0. Repeat with CHUNK=32 -> 1-cycle latency
//  4. sub=1: a=5,b=7,cin=0 -> sum=FFFFFFFE,cout=1,ovf=0. a=80000000,b=1 -> sum=7FFFFFFF,
//     cout=0,ovf=1. a=5,b=2,cin=1 -> sum=2,cout=0
//  5. out_ready low 3 cycles in DONE with in_valid high and new operands -> sum/cout/ovf
//     stable, in_ready=0. Then out_ready=1 -> IDLE; new operands accepted next edge and correct
//  6. rst_n pulsed low after 2 RUN chunks -> out_valid=0, in_ready=1 immediately (async).
//     Next op a=1,b=1 -> sum=2

Source files
------------

// File: rtl/chunked_addsub_seq.sv
// chunked_addsub_seq: multi-cycle ripple adder/subtractor, CHUNK bits per clock with valid/ready handshakes.
module chunked_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  if (WIDTH < 1 || CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("chunked_addsub_seq: WIDTH must be a positive multiple of CHUNK");
  end
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, sub_q, sub_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CHUNK:0] part;
  logic last;
  always_comb begin
    part = {1'b0, a_q[int'(idx_q)*CHUNK +: CHUNK]} + {1'b0, b_q[int'(idx_q)*CHUNK +: CHUNK]}
         + (CHUNK+1)'(carry_q);
    last = idx_q == IW'(NCHUNK - 1);
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    sub_d = sub_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      idx_d = '0;
      a_d = a;
      b_d = sub ? ~b : b;
      carry_d = sub ? ~cin : cin;
      sub_d = sub;
    end
    if (state_q == RUN) begin
      sum_d[int'(idx_q)*CHUNK +: CHUNK] = part[CHUNK-1:0];
      carry_d = part[CHUNK];
      idx_d = idx_q + 1'b1;
      if (last) begin
        state_d = DONE;
        cout_d = sub_q ? ~part[CHUNK] : part[CHUNK];
        // part[CHUNK-1] is the result MSB on the final chunk
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (part[CHUNK-1] != a_q[WIDTH-1]);
      end
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      sub_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      sub_q <= sub_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_chunked_addsub_seq.sv
// tb_chunked_addsub_seq: directed checks of the chunked adder (CHUNK=8) and a single-chunk instance (CHUNK=32).
module tb_chunked_addsub_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic iv4 = 1'b0, iv1 = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic cin = 1'b0, sub = 1'b0;
  logic ir4, ov4, co4, of4, ir1, ov1, co1, of1;
  logic [31:0] s4, s1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  chunked_addsub_seq #(.WIDTH(32), .CHUNK(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov4), .out_ready(out_ready), .sum(s4), .cout(co4), .ovf(of4));
  chunked_addsub_seq #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1));

  // Drives one operation and reports result and accept-to-out_valid latency; scrambles
  // the operand inputs after the accept edge so late changes would corrupt the result.
  task automatic run_op(input bit one, input logic [31:0] ta, tb, input logic tc, ts,
                        output logic [31:0] rs, output logic rc, ro, output int lat);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts;
    if (one) iv1 = 1'b1; else iv4 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0;
    a = $urandom; b = $urandom; cin = ~tc; sub = ~ts;
    lat = 0;
    while (!(one ? ov1 : ov4) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = one ? s1 : s4; rc = one ? co1 : co4; ro = one ? of1 : of4;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #2;
    checks++; if (ir4 !== 1'b1 || ir1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b/%b want 1/1", ir4, ir1); end
    checks++; if (ov4 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b/%b want 0/0", ov4, ov1); end
    checks++; if (s4 !== 32'h0 || co4 !== 1'b0 || of4 !== 1'b0) begin errors++; $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b want 0/0/0", s4, co4, of4); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [31:0] rs; logic rc, ro; int lat;
    run_op(0, 32'h0, 32'h0, 0, 0, rs, rc, ro, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL zero_latency got %0d want 4", lat); end
    checks++; if ({rs, rc, ro} !== {32'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL zero_add got %h/%b/%b want 00000000/0/0", rs, rc, ro); end
    run_op(0, 32'hFFFFFFFF, 32'h1, 0, 0, rs, rc, ro, lat);
    checks++; if ({rs, rc, ro} !== {32'h0, 1'b1, 1'b0}) begin errors++; $display("FAIL carry_wrap got %h/%b/%b want 00000000/1/0", rs, rc, ro); end
    run_op(0, 32'h7FFFFFFF, 32'h1, 0, 0, rs, rc, ro, lat);
    checks++; if ({rs, rc, ro} !== {32'h80000000, 1'b0, 1'b1}) begin errors++; $display("FAIL add_ovf got %h/%b/%b want 80000000/0/1", rs, rc, ro); end
    run_op(0, 32'h12345678, 32'h87654321, 1, 0, rs, rc, ro, lat);
    checks++; if ({rs, rc, ro} !== {32'h9999999A, 1'b0, 1'b0}) begin errors++; $display("FAIL add_cin got %h/%b/%b want 9999999a/0/0", rs, rc, ro); end
    run_op(1, 32'h12345678, 32'h87654321, 1, 0, rs, rc, ro, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL chunk32_latency got %0d want 1", lat); end
    checks++; if ({rs, rc, ro} !== {32'h9999999A, 1'b0, 1'b0}) begin errors++; $display("FAIL chunk32_add got %h/%b/%b want 9999999a/0/0", rs, rc, ro); end
  endtask

  task automatic test_sub;
    logic [31:0] rs; logic rc, ro; int lat;
    run_op(0, 32'h5, 32'h7, 0, 1, rs, rc, ro, lat);
    checks++; if ({rs, rc, ro} !== {32'hFFFFFFFE, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_borrow got %h/%b/%b want fffffffe/1/0", rs, rc, ro); end
    run_op(0, 32'h80000000, 32'h1, 0, 1, rs, rc, ro, lat);
    checks++; if ({rs, rc, ro} !== {32'h7FFFFFFF, 1'b0, 1'b1}) begin errors++; $display("FAIL sub_ovf got %h/%b/%b want 7fffffff/0/1", rs, rc, ro); end
    run_op(0, 32'h5, 32'h2, 1, 1, rs, rc, ro, lat);
    checks++; if ({rs, rc, ro} !== {32'h2, 1'b0, 1'b0}) begin errors++; $display("FAIL sub_bin got %h/%b/%b want 00000002/0/0", rs, rc, ro); end
    run_op(1, 32'h5, 32'h7, 0, 1, rs, rc, ro, lat);
    checks++; if ({rs, rc, ro} !== {32'hFFFFFFFE, 1'b1, 1'b0}) begin errors++; $display("FAIL chunk32_sub got %h/%b/%b want fffffffe/1/0", rs, rc, ro); end
  endtask

  task automatic test_stall;
    int lat;
    @(negedge clk);
    a = 32'h7FFFFFFF; b = 32'h1; cin = 0; sub = 0; iv4 = 1'b1;
    @(posedge clk); #1;
    a = 32'h10; b = 32'h20;
    lat = 0;
    while (!ov4 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL stall_latency got %0d want 4", lat); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({ov4, ir4, s4, co4, of4} !== {1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1}) begin
        errors++; $display("FAIL stall_hold cyc%0d got ov=%b ir=%b %h/%b/%b want 1/0 80000000/0/1", i, ov4, ir4, s4, co4, of4);
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({ov4, ir4} !== 2'b01) begin errors++; $display("FAIL handshake_idle got ov=%b ir=%b want 0/1", ov4, ir4); end
    @(posedge clk); #1;
    iv4 = 1'b0;
    checks++; if (ir4 !== 1'b0) begin errors++; $display("FAIL next_accept in_ready got %b want 0", ir4); end
    lat = 0;
    while (!ov4 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if ({lat, s4, co4, of4} !== {32'd4, 32'h30, 1'b0, 1'b0}) begin
      errors++; $display("FAIL next_op got lat=%0d %h/%b/%b want 4 00000030/0/0", lat, s4, co4, of4);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun;
    logic [31:0] rs; logic rc, ro; int lat;
    @(negedge clk);
    a = 32'h11111111; b = 32'h22222222; cin = 0; sub = 0; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({ov4, ir4} !== 2'b00) begin errors++; $display("FAIL midrun_state got ov=%b ir=%b want 0/0", ov4, ir4); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ov4, ir4, s4} !== {1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL async_reset got ov=%b ir=%b sum=%h want 0/1/00000000", ov4, ir4, s4); end
    @(negedge clk) rst_n = 1'b1;
    run_op(0, 32'h1, 32'h1, 0, 0, rs, rc, ro, lat);
    checks++; if ({lat, rs, rc, ro} !== {32'd4, 32'h2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL after_reset got lat=%0d %h/%b/%b want 4 00000002/0/0", lat, rs, rc, ro);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_stall;
    test_reset_midrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
